// File: rtl/output_giver_serial_if.sv
// Handshake bundle between the cipher core, the serial output stage and the output pins.
// The nibble_ack line is present only when OUT_ACK_EN is defined.
interface output_giver_serial_if #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [NIB_W-1:0]  nibble_out;
  logic              nibble_valid;
  logic              busy;
  logic              done;
`ifdef OUT_ACK_EN
  logic              nibble_ack;

  modport master (
    output load, data_in, nibble_ack,
    input  nibble_out, nibble_valid, busy, done
  );
  modport slave (
    input  load, data_in, nibble_ack,
    output nibble_out, nibble_valid, busy, done
  );
`else
  modport master (
    output load, data_in,
    input  nibble_out, nibble_valid, busy, done
  );
  modport slave (
    input  load, data_in,
    output nibble_out, nibble_valid, busy, done
  );
`endif
endinterface

// File: rtl/output_giver_serial.sv
// Parallel-to-serial output stage: captures a ciphertext word and emits it MSB nibble first.
// Optional downstream flow control is enabled by defining OUT_ACK_EN.
module output_giver_serial #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output_giver_serial_if.slave bus
);
  localparam int NIBS  = DATA_W / NIB_W;
  localparam int CNT_W = $clog2(NIBS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] sreg_reg, sreg_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [NIB_W-1:0]  nibble_reg, nibble_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              ack;

`ifdef OUT_ACK_EN
  assign ack = bus.nibble_ack;
`else
  assign ack = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sreg_reg   <= '0;
      cnt_reg    <= '0;
      nibble_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sreg_reg   <= sreg_next;
      cnt_reg    <= cnt_next;
      nibble_reg <= nibble_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sreg_next   = sreg_reg;
    cnt_next    = cnt_reg;
    nibble_next = nibble_reg;
    valid_next  = valid_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          nibble_next = bus.data_in[DATA_W-1 -: NIB_W];
          valid_next  = 1'b1;
          busy_next   = 1'b1;
          sreg_next   = bus.data_in << NIB_W;
          cnt_next    = CNT_W'(1);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // cnt counts nibbles already presented; the one on the pins is accepted here.
        if (valid_reg && ack) begin
          if (cnt_reg == CNT_W'(NIBS)) begin
            nibble_next = '0;
            valid_next  = 1'b0;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            cnt_next    = '0;
            state_next  = DONE;
          end else begin
            nibble_next = sreg_reg[DATA_W-1 -: NIB_W];
            sreg_next   = sreg_reg << NIB_W;
            cnt_next    = cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.nibble_out   = nibble_reg;
  assign bus.nibble_valid = valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
endmodule

// File: tb/tb_output_giver_serial.sv
// Bench for output_giver_serial: directed scenarios plus random traffic against a word-level model.
module tb_output_giver_serial;
  localparam int DATA_W = 32;
  localparam int NIB_W  = 4;
  localparam int NIBS   = DATA_W / NIB_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  output_giver_serial_if #(.DATA_W(DATA_W), .NIB_W(NIB_W)) bus ();

  output_giver_serial #(.DATA_W(DATA_W), .NIB_W(NIB_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model expectations for the current cycle.
  logic [NIB_W-1:0] e_nib = '0;
  logic             e_valid = 1'b0;
  logic             e_busy = 1'b0;
  logic             e_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NIB_W-1:0] nib_of(input logic [DATA_W-1:0] w, input int idx);
    logic [DATA_W-1:0] s;
    s = w >> (NIB_W * (NIBS - 1 - idx));
    return s[NIB_W-1:0];
  endfunction

  logic ack_now;
  always_comb begin
`ifdef OUT_ACK_EN
    ack_now = bus.nibble_ack;
`else
    ack_now = 1'b1;
`endif
  end

  // Word-level model: phase 0 idle, 1 streaming nibble idx of word, 2 done pulse.
  initial begin
    int phase;
    int idx;
    logic [DATA_W-1:0] word;
    phase = 0; idx = 0; word = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        phase = 0;
      end else if (phase == 0) begin
        if (bus.load) begin
          word = bus.data_in; idx = 0; phase = 1;
        end
      end else if (phase == 1) begin
        if (ack_now) begin
          if (idx == NIBS - 1) phase = 2;
          else idx++;
        end
      end else begin
        phase = 0;
      end
      e_valid = (phase == 1);
      e_busy  = (phase == 1);
      e_done  = (phase == 2);
      e_nib   = (phase == 1) ? nib_of(word, idx) : '0;
      #1;
      check("nibble_out",   32'(bus.nibble_out),   32'(e_nib));
      check("nibble_valid", 32'(bus.nibble_valid), 32'(e_valid));
      check("busy",         32'(bus.busy),         32'(e_busy));
      check("done",         32'(bus.done),         32'(e_done));
    end
  end

  task automatic set_ack(input logic a);
`ifdef OUT_ACK_EN
    bus.nibble_ack = a;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; bus.load = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [NIB_W-1:0] seq [NIBS];
    seq = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'hE, 4'h7, 4'hF};
    bus.load = 1'b0;
    bus.data_in = '0;
    set_ack(1'b1);
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.nibble_valid), 32'd0);
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_done",  32'(bus.done), 32'd0);
    check("reset_nib",   32'(bus.nibble_out), 32'd0);
    reset = 1'b0;

    // Stream 0xA5C31E7F; a load arriving during the cycle-3 nibble must be ignored.
    @(negedge clk); bus.load = 1'b1; bus.data_in = 32'hA5C31E7F;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        check("t1_nib",       32'(bus.nibble_out), 32'(seq[c-1]));
        check("t1_model_nib", 32'(e_nib), 32'(seq[c-1]));
        check("t1_valid",     32'(bus.nibble_valid), 32'd1);
        check("t1_busy",      32'(bus.busy), 32'd1);
        check("t1_done_low",  32'(bus.done), 32'd0);
      end else begin
        check("t1_done",       32'(bus.done), 32'd1);
        check("t1_model_done", 32'(e_done), 32'd1);
        check("t1_busy_end",   32'(bus.busy), 32'd0);
        check("t1_valid_end",  32'(bus.nibble_valid), 32'd0);
      end
      bus.load = (c == 3);
      bus.data_in = (c == 3) ? 32'hFFFFFFFF : 32'h0;
    end

    // Back-to-back words with a single idle cycle after done.
    do_reset();
    @(negedge clk); bus.load = 1'b1; bus.data_in = 32'h12345678;
    @(negedge clk); bus.load = 1'b0;
    wait_done("t3_done_timeout");
    @(negedge clk);
    check("t3_idle_valid", 32'(bus.nibble_valid), 32'd0);
    check("t3_idle_done",  32'(bus.done), 32'd0);
    bus.load = 1'b1; bus.data_in = 32'h9ABCDEF0;
    @(negedge clk); bus.load = 1'b0;
    check("t3_second_first", 32'(bus.nibble_out), 32'h9);
    wait_done("t3_done2_timeout");
    @(negedge clk);

    // Reset after three nibbles: stream discarded, no done pulse.
    do_reset();
    @(negedge clk); bus.load = 1'b1; bus.data_in = 32'hCAFEBABE;
    @(negedge clk); bus.load = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_third_nib", 32'(bus.nibble_out), 32'hF);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t4_valid", 32'(bus.nibble_valid), 32'd0);
    check("t4_busy",  32'(bus.busy), 32'd0);
    check("t4_nib",   32'(bus.nibble_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4_no_done", 32'(bus.done), 32'd0);
    end
    bus.load = 1'b1; bus.data_in = 32'h0F1E2D3C;
    @(negedge clk); bus.load = 1'b0;
    check("t4_restart_nib", 32'(bus.nibble_out), 32'h0);
    check("t4_restart_valid", 32'(bus.nibble_valid), 32'd1);
    wait_done("t4_done_timeout");
    @(negedge clk);

    // Reset and load in the same cycle: reset wins.
    @(negedge clk); reset = 1'b1; bus.load = 1'b1; bus.data_in = 32'h55AA55AA;
    @(negedge clk); reset = 1'b0; bus.load = 1'b0;
    check("t5_valid", 32'(bus.nibble_valid), 32'd0);
    check("t5_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t5_valid_later", 32'(bus.nibble_valid), 32'd0);

`ifdef OUT_ACK_EN
    // Stall on nibble 5 for three cycles.
    do_reset();
    @(negedge clk); bus.load = 1'b1; bus.data_in = 32'hA5C31E7F;
    @(negedge clk); bus.load = 1'b0;
    @(negedge clk); set_ack(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_hold_nib",   32'(bus.nibble_out), 32'h5);
      check("t6_hold_valid", 32'(bus.nibble_valid), 32'd1);
    end
    set_ack(1'b1);
    @(negedge clk);
    check("t6_resume_nib", 32'(bus.nibble_out), 32'hC);
    wait_done("t6_done_timeout");
    @(negedge clk);
`endif

    // Random traffic checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 2);
      bus.load = ($urandom_range(0, 99) < 30);
      bus.data_in = $urandom;
      set_ack($urandom_range(0, 99) < 70);
    end
    @(negedge clk); reset = 1'b0; bus.load = 1'b0; set_ack(1'b1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
